// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Purpose:
//   Stall/flush sequencer for the ID-stage branch resolution path. The block
//   compares the instruction in IF/ID with the producers in ID/EX and EX/MEM.
//   It works out how many bubble cycles are needed before the ID-stage
//   comparator can use forwarded operands. It then holds the front end for
//   exactly that many cycles. A taken branch flushes IF/ID once its operands
//   are valid.
//
// Ports:
//   clk              in   pipeline clock, rising edge
//   reset            in   asynchronous, active-high reset
//   if_id_rs/rt      in   [4:0] source registers of the ID-stage instruction
//   I_type           in   ID instruction is I-type (rt is a destination)
//   branch           in   ID instruction is a conditional branch
//   branch_taken     in   ID-stage comparator result (valid when branch=1)
//   id_ex_rd         in   [4:0] destination of the instruction in EX
//   id_ex_regwrite   in   EX instruction writes the register file
//   id_ex_memread    in   EX instruction is a load
//   ex_mem_rd        in   [4:0] destination of the instruction in MEM
//   ex_mem_regwrite  in   MEM instruction writes the register file
//   ex_mem_memread   in   MEM instruction is a load
//   ext_stall        in   external freeze (memory busy), highest priority
//   pc_write         out  PC load enable
//   if_id_write      out  IF/ID load enable
//   id_ex_bubble     out  zero the ID/EX control fields this cycle
//   if_id_flush      out  clear IF/ID to a NOP on the next edge
//   stall            out  front end held this cycle
//   stall_cycles     out  [15:0] saturating hazard-stall counter (optional)
//   flush_count      out  [15:0] saturating flush counter (optional)
//
// Configuration:
//   HAZARD_PERF_EN   when defined, adds the stall_cycles and flush_count
//                    performance counters. When it is undefined, those ports
//                    and their registers are not present.
// ---------------------------------------------------------------------------
module branch_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        I_type,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_regwrite,
    input  logic        id_ex_memread,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_regwrite,
    input  logic        ex_mem_memread,
    input  logic        ext_stall,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        stall
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] r_state;
    logic       r_cnt;

    logic       w_usesRt;
    logic       w_idExMatch;
    logic       w_exMemMatch;
    logic       w_needOne;
    logic       w_needTwo;
    logic       w_hazardStall;
    logic       w_cntNext;

    // Under MIPS-style encoding, a non-branch I-type writes rt and does not
    // read it. Branches read both rs and rt. Register 0 is hard-wired to zero,
    // so it never creates a dependency.
    always_comb begin
        w_usesRt     = branch | ~I_type;
        w_idExMatch  = (id_ex_rd != 5'd0) &&
                       ((id_ex_rd == if_id_rs) || (w_usesRt && (id_ex_rd == if_id_rt)));
        w_exMemMatch = (ex_mem_rd != 5'd0) &&
                       ((ex_mem_rd == if_id_rs) || (w_usesRt && (ex_mem_rd == if_id_rt)));
    end

    // Bubble requirement. The branch comparator sits in ID, so it needs
    // operands a stage earlier than an ALU op does.
    //   An ALU result in EX costs a branch one bubble.
    //   A load in EX costs a branch two bubbles.
    //   A load in MEM costs a branch one bubble.
    //   A load in EX costs an ordinary instruction one bubble (load-use).
    // ex_mem_regwrite is not needed here: a non-load in MEM can already be
    // forwarded to the comparator.
    always_comb begin
        w_needTwo = branch & id_ex_memread & w_idExMatch;
        w_needOne = (~branch & id_ex_memread & w_idExMatch) |
                    (branch & id_ex_regwrite & ~id_ex_memread & w_idExMatch) |
                    (branch & ex_mem_memread & w_exMemMatch);
    end

    // HOLD always stalls and does not look at the inputs again. The second
    // bubble of a branch after a load therefore survives the pipeline
    // advancing underneath it.
    always_comb begin
        w_hazardStall = (r_state == HOLD) | w_needOne | w_needTwo;
    end

    // Remaining-bubble count after the current HOLD cycle. It floors at zero.
    always_comb begin
        w_cntNext = (r_cnt != 1'b0) ? (r_cnt - 1'b1) : 1'b0;
    end

    // Output decode, in priority order: reset, external freeze, hazard stall,
    // normal run. The PC must not redirect while the branch operands are
    // stale, so a taken branch only flushes in the normal-run leg.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        stall        = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall        = 1'b1;
        end else if (ext_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            stall        = 1'b1;
        end else if (w_hazardStall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall        = 1'b1;
        end else begin
            if_id_flush  = branch & branch_taken;
        end
    end

    // Sequencer state. An external freeze holds the state and the count, so
    // frozen cycles are not counted as hazard bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 1'b0;
        end else if (!ext_stall) begin
            case (r_state)
                RUN: begin
                    if (w_needTwo) begin
                        r_state <= HOLD;
                        r_cnt   <= 1'b1;
                    end
                end
                HOLD: begin
                    r_cnt   <= w_cntNext;
                    r_state <= (w_cntNext == 1'b0) ? RUN : HOLD;
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stallCycles;
    logic [15:0] r_flushCount;

    // Saturating performance counters. Only hazard stalls are counted.
    // Reset and external-freeze cycles are excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCycles <= 16'd0;
            r_flushCount  <= 16'd0;
        end else begin
            if (!ext_stall && w_hazardStall && (r_stallCycles != 16'hFFFF))
                r_stallCycles <= r_stallCycles + 16'd1;
            if (if_id_flush && (r_flushCount != 16'hFFFF))
                r_flushCount <= r_flushCount + 16'd1;
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_ctrl
//
// Purpose:
//   Directed testbench for branch_hazard_ctrl. A behavioural model tracks
//   "bubbles still owed" as a plain integer. The model is checked against the
//   DUT on every falling edge. Hand-computed literal vectors pin both the DUT
//   and the model at key points.
//
// Configuration:
//   HAZARD_PERF_EN   when defined, the bench also connects and checks the
//                    performance counters.
// ---------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    // Expected output vectors, packed as {pc_write, if_id_write, id_ex_bubble,
    // if_id_flush, stall}.
    localparam logic [4:0] OUT_RUN   = 5'b11000;
    localparam logic [4:0] OUT_HAZ   = 5'b00101;
    localparam logic [4:0] OUT_FRZ   = 5'b00001;
    localparam logic [4:0] OUT_RST   = 5'b00101;
    localparam logic [4:0] OUT_FLUSH = 5'b11010;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic       I_type, branch, branch_taken;
    logic       id_ex_regwrite, id_ex_memread, ex_mem_regwrite, ex_mem_memread;
    logic       ext_stall;
    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, stall;

    int total = 0;
    int bad   = 0;

    // Model state: the number of forced bubbles still owed beyond the
    // current cycle, plus counter shadows.
    int holdLeft      = 0;
    int modelStalls   = 0;
    int modelFlushes  = 0;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    branch_hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .I_type         (I_type),
        .branch         (branch),
        .branch_taken   (branch_taken),
        .id_ex_rd       (id_ex_rd),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_memread  (id_ex_memread),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_regwrite(ex_mem_regwrite),
        .ex_mem_memread (ex_mem_memread),
        .ext_stall      (ext_stall),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .stall          (stall)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    // Does the ID instruction read register rd? Register 0 never counts.
    function automatic bit readsReg(input logic [4:0] rd);
        bit rtIsSource;
        rtIsSource = branch || !I_type;
        if (rd == 5'd0) return 1'b0;
        return (rd == if_id_rs) || (rtIsSource && rd == if_id_rt);
    endfunction

    // Bubbles the current ID instruction needs. This is the largest of all
    // the applicable rules.
    function automatic int neededBubbles();
        int n;
        n = 0;
        if (!branch && id_ex_memread && readsReg(id_ex_rd)) n = (n > 1) ? n : 1;
        if (branch && readsReg(id_ex_rd)) begin
            if (id_ex_memread) n = 2;
            else if (id_ex_regwrite) n = (n > 1) ? n : 1;
        end
        if (branch && ex_mem_memread && readsReg(ex_mem_rd)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    function automatic logic [4:0] modelOut();
        if (reset) return OUT_RST;
        if (ext_stall) return OUT_FRZ;
        if (holdLeft > 0 || neededBubbles() > 0) return OUT_HAZ;
        return {2'b11, 1'b0, branch && branch_taken, 1'b0};
    endfunction

    // Advance the model on each clock edge. A freeze leaves everything as it
    // is. A two-bubble hazard still owes one more bubble after this cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            holdLeft     <= 0;
            modelStalls  <= 0;
            modelFlushes <= 0;
        end else if (!ext_stall) begin
            if (modelOut() == OUT_HAZ && modelStalls < 65535) modelStalls <= modelStalls + 1;
            if (modelOut() == OUT_FLUSH && modelFlushes < 65535) modelFlushes <= modelFlushes + 1;
            if (holdLeft > 0) holdLeft <= holdLeft - 1;
            else if (neededBubbles() == 2) holdLeft <= 1;
        end
    end

    // Compare the DUT against the model on every cycle, away from the active
    // clock edge.
    always @(negedge clk) begin
        total++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, stall} !== modelOut()) begin
            bad++;
            $display("[TB] FAIL cycle-compare t=%0t got=%b want=%b", $time,
                     {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall}, modelOut());
        end
`ifdef HAZARD_PERF_EN
        total++;
        if (stall_cycles !== 16'(modelStalls) || flush_count !== 16'(modelFlushes)) begin
            bad++;
            $display("[TB] FAIL counter-compare t=%0t got=%0d/%0d want=%0d/%0d", $time,
                     stall_cycles, flush_count, modelStalls, modelFlushes);
        end
`endif
    end

    // Drive the inputs for the coming cycle. Called just after a rising edge.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic it, input logic br, input logic tk,
                                 input logic [4:0] exRd, input logic exW, input logic exR,
                                 input logic [4:0] memRd, input logic memW, input logic memR,
                                 input logic ext);
        if_id_rs        = rs;
        if_id_rt        = rt;
        I_type          = it;
        branch          = br;
        branch_taken    = tk;
        id_ex_rd        = exRd;
        id_ex_regwrite  = exW;
        id_ex_memread   = exR;
        ex_mem_rd       = memRd;
        ex_mem_regwrite = memW;
        ex_mem_memread  = memR;
        ext_stall       = ext;
    endtask

    task automatic applyIdle();
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check the DUT and the model against a literal at the falling edge,
    // then move to just after the next rising edge.
    task automatic checkOutput(input string name, input logic [4:0] want);
        @(negedge clk);
        total++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, stall} !== want) begin
            bad++;
            $display("[TB] FAIL %s dut=%b want=%b", name,
                     {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall}, want);
        end
        total++;
        if (modelOut() !== want) begin
            bad++;
            $display("[TB] FAIL %s-model model=%b want=%b", name, modelOut(), want);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic checkCounters(input string name, input int wantStalls, input int wantFlushes);
        total++;
        if (stall_cycles !== 16'(wantStalls) || flush_count !== 16'(wantFlushes)) begin
            bad++;
            $display("[TB] FAIL %s got=%0d/%0d want=%0d/%0d", name,
                     stall_cycles, flush_count, wantStalls, wantFlushes);
        end
    endtask
`endif

    task automatic pulseReset();
        reset = 1'b1;
        checkOutput("reset-pulse", OUT_RST);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyIdle();
        checkOutput("reset-state", OUT_RST);
        reset = 1'b0;
        checkOutput("idle-run", OUT_RUN);

        // Load-use on rs: one bubble, then normal run once the load moves on.
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("load-use", OUT_HAZ);
        applyIdle();
        checkOutput("load-use-after", OUT_RUN);

        // Branch after a load on rt: two bubbles. The second holds even
        // though the inputs no longer show a hazard.
        applyStimulus(5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("br-load-1", OUT_HAZ);
        applyIdle();
        checkOutput("br-load-2", OUT_HAZ);
        checkOutput("br-load-done", OUT_RUN);

        // Register 0 never matches. An I-type rt is a destination.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reg0-branch", OUT_RUN);
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("itype-rt", OUT_RUN);

        // Taken branch with no hazard flushes with pc_write=1.
        applyStimulus(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("taken-flush", OUT_FLUSH);
        applyIdle();
        checkOutput("flush-one-cycle", OUT_RUN);

        // Taken branch behind an ALU producer: stall first, then flush.
        applyStimulus(5'd4, 5'd8, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("taken-alu-stall", OUT_HAZ);
        applyStimulus(5'd4, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        checkOutput("taken-after-stall", OUT_FLUSH);

        // A load in MEM feeding a branch costs one bubble.
        applyStimulus(5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        checkOutput("br-memload", OUT_HAZ);
        applyIdle();
        checkOutput("br-memload-done", OUT_RUN);

        // An external freeze overrides a flush and a hazard.
        applyStimulus(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("ext-over-flush", OUT_FRZ);
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("ext-over-hazard", OUT_FRZ);
        applyIdle();
        checkOutput("ext-release", OUT_RUN);

        // Freeze mid-HOLD: the owed bubble is preserved across 3 frozen cycles.
        pulseReset();
        applyStimulus(5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold-ext-1", OUT_HAZ);
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) checkOutput("hold-frozen", OUT_FRZ);
        applyIdle();
        checkOutput("hold-ext-2", OUT_HAZ);
        checkOutput("hold-ext-done", OUT_RUN);
`ifdef HAZARD_PERF_EN
        checkCounters("perf-after-freeze", 2, 0);
`endif

        // Reset asserted mid-HOLD takes effect at once. After release the
        // sequencer runs normally.
        applyStimulus(5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst-hold-1", OUT_HAZ);
        applyIdle();
        reset = 1'b1;
        checkOutput("rst-mid-hold", OUT_RST);
        reset = 1'b0;
        checkOutput("rst-release", OUT_RUN);
`ifdef HAZARD_PERF_EN
        checkCounters("perf-after-reset", 0, 0);
`endif
        checkOutput("rst-run", OUT_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
